multicycle_datapath: RTL and testbench

Parametrised multicycle MIPS core datapath with an integrated control FSM. It fetches instructions and accesses data through one shared memory port using a req/ready handshake, so memory wait states stall the FSM. Width is generalised to DATA_W. Signed-add overflow raises a precise exception that redirects the PC to EXC_VEC. It sits between the top level and a unified instruction/data memory.

---
 rtl/multicycle_datapath.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: datapath plus control FSM on one shared memory port.
// Memory wait states stall the FSM; signed add/sub overflow traps to EXC_VEC.
module multicycle_datapath #(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  RESET_PC = '0,
  parameter logic [DATA_W-1:0]  EXC_VEC  = DATA_W'('h80)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] pc,
  output logic              exc,
  output logic [DATA_W-1:0] epc,
  output logic              halted
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC   = 4'd2;
  localparam logic [3:0] S_ALUWB  = 4'd3;
  localparam logic [3:0] S_MEMADR = 4'd4;
  localparam logic [3:0] S_MEMRD  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_BRANCH = 4'd7;
  localparam logic [3:0] S_JUMP   = 4'd8;
  localparam logic [3:0] S_HALT   = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam int MSB = DATA_W - 1;

  logic [3:0]        state;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b, aluout, target;
  logic [DATA_W-1:0] regs [32];

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] imm_sext;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign halted   = (state == S_HALT);

  logic [3:0] decode_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    decode_next = S_HALT;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: decode_next = S_EXEC;
          default:                          decode_next = S_HALT;
        endcase
      end
      OP_ADDI:      decode_next = S_EXEC;
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_BEQ:       decode_next = S_BRANCH;
      OP_J:         decode_next = S_JUMP;
      default:      decode_next = S_HALT;
    endcase
  end

  logic [DATA_W-1:0] alu_b, sum, diff, alu_y;
  logic              add_ovf, sub_ovf, alu_ovf;

  assign alu_b   = (op == OP_ADDI) ? imm_sext : b;
  assign sum     = a + alu_b;
  assign diff    = a - alu_b;
  assign add_ovf = (a[MSB] == alu_b[MSB]) && (sum[MSB]  != a[MSB]);
  assign sub_ovf = (a[MSB] != alu_b[MSB]) && (diff[MSB] != a[MSB]);

  always_comb begin
    alu_y   = '0;
    alu_ovf = 1'b0;
    if (op == OP_ADDI) begin
      alu_y   = sum;
      alu_ovf = add_ovf;
    end else begin
      case (funct)
        F_ADD: begin alu_y = sum;  alu_ovf = add_ovf; end
        F_SUB: begin alu_y = diff; alu_ovf = sub_ovf; end
        F_AND: alu_y = a & b;
        F_OR:  alu_y = a | b;
        F_SLT: alu_y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
        default: alu_y = '0;
      endcase
    end
  end

  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (state == S_ALUWB) begin
      rf_we    = 1'b1;
      rf_waddr = (op == OP_RTYPE) ? rd : rt;
      rf_wdata = aluout;
    end else if (state == S_MEMRD && mem_ready) begin
      rf_we    = 1'b1;
      rf_waddr = rt;
      rf_wdata = mem_rdata;
    end
    // $0 is hardwired: dropping its writes keeps every read of it at zero.
    if (rf_waddr == 5'd0) rf_we = 1'b0;
  end

  // NOTE: the register file is cleared on reset because software may read any register before writing it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // Bus outputs decode straight from state, gated by reset so an abandoned access drops at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      case (state)
        S_FETCH: begin mem_req = 1'b1; mem_addr = pc; end
        S_MEMRD: begin mem_req = 1'b1; mem_addr = aluout; end
        S_MEMWR: begin mem_req = 1'b1; mem_we = 1'b1; mem_addr = aluout; mem_wdata = b; end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      target <= '0;
      exc    <= 1'b0;
      epc    <= '0;
    end else begin
      exc <= 1'b0;
      case (state)
        S_FETCH: if (mem_ready) begin
          ir    <= mem_rdata[31:0];
          pc    <= pc + DATA_W'(4);
          state <= S_DECODE;
        end
        S_DECODE: begin
          a      <= regs[rs];
          b      <= regs[rt];
          target <= pc + (imm_sext << 2);
          state  <= decode_next;
        end
        S_EXEC: begin
          if (alu_ovf) begin
            epc   <= pc - DATA_W'(4);
            pc    <= EXC_VEC;
            exc   <= 1'b1;
            state <= S_FETCH;
          end else begin
            aluout <= alu_y;
            state  <= S_ALUWB;
          end
        end
        S_ALUWB:  state <= S_FETCH;
        S_MEMADR: begin
          aluout <= a + imm_sext;
          state  <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD, S_MEMWR: if (mem_ready) state <= S_FETCH;
        S_BRANCH: begin
          if (a == b) pc <= target;
          state <= S_FETCH;
        end
        S_JUMP: begin
          pc    <= {pc[DATA_W-1:28], ir[25:0], 2'b00};
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: a word memory with programmable wait states
// records fetches and stores; each task loads a small program and checks the bus log.
module tb_multicycle_datapath;

  localparam int          DW     = 32;
  localparam int          WORDS  = 128;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_req, mem_we, mem_ready = 1'b0;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata, pc, epc;
  logic          exc, halted;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_datapath #(.DATA_W(DW), .RESET_PC(32'h0), .EXC_VEC(32'h80)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .exc(exc), .epc(epc), .halted(halted)
  );

  // Memory model: img is the program image loaded while reset is low; mem is the live copy.
  logic [31:0] img [WORDS];
  logic [31:0] mem [WORDS];
  int          wait_n = 0;
  int          wcnt, cyc, unstable, exc_cnt;
  logic        pending;
  logic          s_we;
  logic [DW-1:0] s_addr, s_wdata;
  int          fetch_cyc [$];
  logic [31:0] fetch_addr [$];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];

  assign mem_rdata = mem[mem_addr[8:2]];

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] = img[i];
      mem_ready = 1'b0;
      wcnt = 0; cyc = 0; unstable = 0; exc_cnt = 0; pending = 1'b0;
      fetch_cyc.delete(); fetch_addr.delete(); wr_addr.delete(); wr_data.delete();
    end else begin
      cyc++;
      if (exc) exc_cnt++;
      if (mem_req) begin
        if (pending && (mem_we !== s_we || mem_addr !== s_addr || mem_wdata !== s_wdata))
          unstable++;
        if (wcnt == wait_n) begin
          mem_ready = 1'b1;
          wcnt = 0;
          pending = 1'b0;
          if (mem_we) begin
            mem[mem_addr[8:2]] = mem_wdata;
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
          end else if (mem_addr == pc) begin
            fetch_addr.push_back(mem_addr);
            fetch_cyc.push_back(cyc);
          end
        end else begin
          mem_ready = 1'b0;
          wcnt++;
          pending = 1'b1;
          s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
        pending = 1'b0;
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < WORDS; i++) img[i] = HALT_W;
  endtask

  task automatic begin_test(input int w);
    reset = 1'b0;
    wait_n = w;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (halted) break;
    end
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_halt_timeout: halted=%b after %0d cycles, required 1", name, halted, budget);
    end
  endtask

  task automatic test_reset();
    clear_img();
    img[0] = enc_i(6'h2B, 5'd0, 5'd1,  16'h0040);
    img[1] = enc_i(6'h2B, 5'd0, 5'd31, 16'h0044);
    reset = 1'b0;
    wait_n = 0;
    repeat (3) @(negedge clk); #1;
    vectors++;
    if ({mem_req, mem_we, exc, halted} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: {req,we,exc,halted}=%b, required 0000", {mem_req, mem_we, exc, halted});
    end
    vectors++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_bus: addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
    end
    vectors++;
    if ({pc, epc} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_pc_epc: pc=%h epc=%h, required 0", pc, epc);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL first_fetch: req=%b we=%b addr=%h, required 1 0 0", mem_req, mem_we, mem_addr);
    end
    run_to_halt(50, "reset");
    vectors++;
    if (wr_data.size() != 2) begin
      miscompares++;
      $display("FAIL reset_store_count: %0d stores, required 2", wr_data.size());
    end else begin
      vectors++;
      if (wr_addr[0] !== 32'h40 || wr_data[0] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_reg1: [%h]=%h, required [40]=0", wr_addr[0], wr_data[0]);
      end
      vectors++;
      if (wr_addr[1] !== 32'h44 || wr_data[1] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_reg31: [%h]=%h, required [44]=0", wr_addr[1], wr_data[1]);
      end
    end
  endtask

  task automatic test_alu();
    logic [31:0] exp_w [6];
    exp_w = '{32'd2, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd1, 32'd0};
    clear_img();
    img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    img[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    img[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    img[3] = enc_r(5'd1, 5'd2, 5'd4, 6'h22);
    img[4] = enc_r(5'd1, 5'd2, 5'd5, 6'h24);
    img[5] = enc_r(5'd1, 5'd2, 5'd6, 6'h25);
    img[6] = enc_r(5'd2, 5'd1, 5'd7, 6'h2A);
    img[7] = enc_r(5'd1, 5'd2, 5'd8, 6'h2A);
    for (int i = 0; i < 6; i++) img[8+i] = enc_i(6'h2B, 5'd0, 5'(3+i), 16'(64 + 4*i));
    begin_test(0);
    run_to_halt(200, "alu");
    vectors++;
    if (fetch_cyc.size() != 15) begin
      miscompares++;
      $display("FAIL alu_fetch_count: %0d fetches, required 15", fetch_cyc.size());
    end else begin
      vectors++;
      if (fetch_addr[3] !== 32'd12 || fetch_cyc[3] - fetch_cyc[0] != 12) begin
        miscompares++;
        $display("FAIL alu_three_instr: 4th fetch addr=%h after %0d cycles, required 0c after 12",
                 fetch_addr[3], fetch_cyc[3] - fetch_cyc[0]);
      end
      vectors++;
      if (fetch_cyc[4] - fetch_cyc[3] != 4) begin
        miscompares++;
        $display("FAIL rtype_latency: %0d cycles, required 4", fetch_cyc[4] - fetch_cyc[3]);
      end
      vectors++;
      if (fetch_cyc[9] - fetch_cyc[8] != 4) begin
        miscompares++;
        $display("FAIL sw_latency: %0d cycles, required 4", fetch_cyc[9] - fetch_cyc[8]);
      end
    end
    vectors++;
    if (wr_data.size() != 6) begin
      miscompares++;
      $display("FAIL alu_store_count: %0d stores, required 6", wr_data.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (wr_addr[i] !== 32'(64 + 4*i) || wr_data[i] !== exp_w[i]) begin
          miscompares++;
          $display("FAIL alu_result_%0d: [%h]=%h, required [%h]=%h",
                   i, wr_addr[i], wr_data[i], 32'(64 + 4*i), exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_mem_wait();
    clear_img();
    img[0]  = enc_i(6'h08, 5'd0, 5'd3, 16'd2);
    img[1]  = enc_i(6'h2B, 5'd0, 5'd3, 16'h0048);
    img[2]  = enc_i(6'h23, 5'd0, 5'd4, 16'h0048);
    img[3]  = enc_i(6'h2B, 5'd0, 5'd4, 16'h004C);
    img[18] = 32'hDEAD_BEEF;
    begin_test(3);
    run_to_halt(200, "mem");
    vectors++;
    if (unstable != 0) begin
      miscompares++;
      $display("FAIL req_stability: %0d changes during wait, required 0", unstable);
    end
    vectors++;
    if (wr_data.size() != 2) begin
      miscompares++;
      $display("FAIL mem_store_count: %0d stores, required 2", wr_data.size());
    end else begin
      vectors++;
      if (wr_addr[0] !== 32'h48 || wr_data[0] !== 32'd2) begin
        miscompares++;
        $display("FAIL sw_wait: [%h]=%h, required [48]=2", wr_addr[0], wr_data[0]);
      end
      vectors++;
      if (wr_addr[1] !== 32'h4C || wr_data[1] !== 32'd2) begin
        miscompares++;
        $display("FAIL lw_wait: [%h]=%h, required [4c]=2", wr_addr[1], wr_data[1]);
      end
    end
    vectors++;
    if (fetch_cyc.size() != 5) begin
      miscompares++;
      $display("FAIL mem_fetch_count: %0d fetches, required 5", fetch_cyc.size());
    end else begin
      vectors++;
      if (fetch_cyc[1] - fetch_cyc[0] != 7) begin
        miscompares++;
        $display("FAIL addi_wait_latency: %0d cycles, required 7", fetch_cyc[1] - fetch_cyc[0]);
      end
      vectors++;
      if (fetch_cyc[2] - fetch_cyc[1] != 10 || fetch_cyc[3] - fetch_cyc[2] != 10) begin
        miscompares++;
        $display("FAIL memop_wait_latency: sw %0d lw %0d cycles, required 10 10",
                 fetch_cyc[2] - fetch_cyc[1], fetch_cyc[3] - fetch_cyc[2]);
      end
    end
  endtask

  task automatic test_overflow();
    clear_img();
    img[0]  = enc_i(6'h23, 5'd0, 5'd1, 16'h0060);
    img[1]  = enc_i(6'h08, 5'd1, 5'd1, 16'd1);
    img[24] = 32'h7FFF_FFFF;
    img[32] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0040);
    begin_test(0);
    run_to_halt(100, "ovf");
    vectors++;
    if (exc_cnt != 1) begin
      miscompares++;
      $display("FAIL exc_pulse: exc high %0d cycles, required 1", exc_cnt);
    end
    vectors++;
    if (epc !== 32'h4) begin
      miscompares++;
      $display("FAIL epc: got %h, required 00000004", epc);
    end
    vectors++;
    if (fetch_addr.size() < 3 || fetch_addr[2] !== 32'h80) begin
      miscompares++;
      $display("FAIL exc_vector: %0d fetches, third addr %h, required 00000080",
               fetch_addr.size(), (fetch_addr.size() < 3) ? 32'hx : fetch_addr[2]);
    end
    vectors++;
    if (wr_data.size() != 1 || wr_data[0] !== 32'h7FFF_FFFF) begin
      miscompares++;
      $display("FAIL ovf_no_write: %0d stores, first %h, required 1 store of 7fffffff",
               wr_data.size(), (wr_data.size() == 0) ? 32'hx : wr_data[0]);
    end
  endtask

  task automatic test_branch_jump();
    logic [31:0] exp_f [7];
    exp_f = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h100, 32'h104, 32'h108};
    clear_img();
    img[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    img[1]  = enc_i(6'h04, 5'd1, 5'd0, 16'd5);
    img[2]  = enc_i(6'h04, 5'd0, 5'd0, 16'd1);
    img[3]  = enc_i(6'h2B, 5'd0, 5'd1, 16'h0044);
    img[4]  = enc_j(26'h40);
    img[64] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    img[65] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0040);
    begin_test(0);
    run_to_halt(100, "branch");
    vectors++;
    if (fetch_addr.size() != 7) begin
      miscompares++;
      $display("FAIL flow_fetch_count: %0d fetches, required 7", fetch_addr.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (fetch_addr[i] !== exp_f[i]) begin
          miscompares++;
          $display("FAIL flow_pc_%0d: got %h, required %h", i, fetch_addr[i], exp_f[i]);
        end
      end
      vectors++;
      if (fetch_cyc[2] - fetch_cyc[1] != 3 || fetch_cyc[4] - fetch_cyc[3] != 3) begin
        miscompares++;
        $display("FAIL beq_j_latency: beq %0d j %0d cycles, required 3 3",
                 fetch_cyc[2] - fetch_cyc[1], fetch_cyc[4] - fetch_cyc[3]);
      end
    end
    vectors++;
    if (wr_data.size() != 1 || wr_addr[0] !== 32'h40 || wr_data[0] !== 32'h0) begin
      miscompares++;
      $display("FAIL reg0_write: %0d stores, first %h, required 1 store of 0 to 40",
               wr_data.size(), (wr_data.size() == 0) ? 32'hx : wr_data[0]);
    end
  endtask

  task automatic test_branch_loop();
    int off;
    clear_img();
    img[0] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    begin_test(0);
    repeat (16) @(negedge clk);
    #1;
    off = 0;
    foreach (fetch_addr[i]) if (fetch_addr[i] !== 32'h0) off++;
    vectors++;
    if (fetch_addr.size() != 6) begin
      miscompares++;
      $display("FAIL loop_fetch_count: %0d fetches in 16 cycles, required 6", fetch_addr.size());
    end
    vectors++;
    if (off != 0) begin
      miscompares++;
      $display("FAIL loop_addr: %0d fetches away from 0, required 0", off);
    end
  endtask

  task automatic test_halt_reset();
    int  bad;
    bit  found;
    clear_img();
    begin_test(0);
    bad = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (halted && mem_req) bad++;
    end
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_flag: got %b, required 1", halted);
    end
    vectors++;
    if (bad != 0 || fetch_addr.size() != 1) begin
      miscompares++;
      $display("FAIL halt_quiet: %0d requests while halted, %0d fetches, required 0 and 1",
               bad, fetch_addr.size());
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_cleared: got %b, required 0", halted);
    end
    img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    begin_test(5);
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (mem_req && mem_addr == 32'h4) begin
        found = 1'b1;
        break;
      end
    end
    vectors++;
    if (!found || pc !== 32'h4) begin
      miscompares++;
      $display("FAIL second_fetch_wait: found=%b pc=%h, required 1 00000004", found, pc);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || pc !== 32'h0) begin
      miscompares++;
      $display("FAIL async_abort: req=%b pc=%h, required 0 00000000", mem_req, pc);
    end
  endtask

  initial begin
    clear_img();
    test_reset();
    test_alu();
    test_mem_wait();
    test_overflow();
    test_branch_jump();
    test_branch_loop();
    test_halt_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
